// File: rtl/lvds_pkg.sv
// Shared LVDS definitions: deskew state encoding, default sync marker and a
// constant-function clog2 shared with the PHY blocks.
package lvds_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2,
    ST_ERROR  = 2'd3
  } deskew_state_e;

  localparam logic [3:0] C_SYNC_WORD_DEF = 4'b1100;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lvds_deskew_fifo.sv
// Per-lane skew FIFO: synchronous write/pop, flush has priority, head is the
// oldest stored word and occ_o is the current fill level.
module lvds_deskew_fifo
  import lvds_pkg::*;
#(
  parameter int C_WIDTH = 4,
  parameter int C_DEPTH = 8,
  parameter int C_OCC_W = clog2(C_DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               flush_i,
  input  logic               wr_i,
  input  logic               pop_i,
  input  logic [C_WIDTH-1:0] wr_data_i,
  output logic [C_WIDTH-1:0] head_o,
  output logic [C_OCC_W-1:0] occ_o,
  output logic               empty_o
);

  localparam int AW = clog2(C_DEPTH);

  logic [C_WIDTH-1:0] mem_q [C_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [C_OCC_W-1:0] occ_q;
  logic               pop_eff;

  assign empty_o = (occ_q == '0);
  assign pop_eff = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign occ_o   = occ_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (wr_i)    wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_eff) rd_ptr_q <= rd_ptr_q + AW'(1);
      occ_q <= occ_q + C_OCC_W'(wr_i) - C_OCC_W'(pop_eff);
    end
  end

  // Storage needs no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_i && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/lvds_rx_lane_deskew.sv
// Lane deskew: aligns per-lane words on a periodic sync marker via skew FIFOs.
// Optional macro LVDS_DESKEW_SKEW_MON_EN adds LANE_SKEW_O (occupancy at lock).
//
// state  | meaning
// IDLE   | FIFOs flushed, waiting for all lanes byte-aligned
// SEARCH | FIFOs fill; each lane parks on its sync word until all lanes park
// LOCKED | all lanes pop together, lane-coherent data out every cycle
// ERROR  | skew too large or timeout; flushed until DESKEW_REQ_I
module lvds_rx_lane_deskew
  import lvds_pkg::*;
#(
  parameter int C_LANE_NUM            = 2,
  parameter int C_DATA_WIDTH_PER_LANE = 4,
  parameter int C_FIFO_DEPTH          = 8,
  parameter logic [C_DATA_WIDTH_PER_LANE-1:0] C_SYNC_WORD =
    C_DATA_WIDTH_PER_LANE'(C_SYNC_WORD_DEF),
  parameter int C_TIMEOUT             = 256
) (
  input  logic                                        CLKDIV_I,
  input  logic                                        CLKDIV_RST_N_I,
  input  logic [C_LANE_NUM*C_DATA_WIDTH_PER_LANE-1:0] LANE_DATA_I,
  input  logic [C_LANE_NUM-1:0]                       BYTE_ALIGN_I,
  input  logic                                        DESKEW_REQ_I,
  output logic [C_LANE_NUM*C_DATA_WIDTH_PER_LANE-1:0] DATA_O,
  output logic                                        DATA_VLD_O,
  output logic                                        DESKEW_DONE_O,
  output logic                                        DESKEW_ERR_O
`ifdef LVDS_DESKEW_SKEW_MON_EN
  ,output logic [C_LANE_NUM*clog2(C_FIFO_DEPTH)-1:0]  LANE_SKEW_O
`endif
);

  localparam int W     = C_DATA_WIDTH_PER_LANE;
  localparam int AW    = clog2(C_FIFO_DEPTH);
  localparam int OCC_W = clog2(C_FIFO_DEPTH + 1);
  localparam int TMO_W = clog2(C_TIMEOUT + 1);

  deskew_state_e          state_q, state_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [C_LANE_NUM*W-1:0] data_q, heads;
  logic                   vld_q;

  logic [W-1:0]           head  [C_LANE_NUM];
  logic [OCC_W-1:0]       occ   [C_LANE_NUM];
  logic [C_LANE_NUM-1:0]  empty, hold, pop_lane, pop;
  logic                   ba_ok, all_hold, any_full, pop_all, wr, flush;

  for (genvar k = 0; k < C_LANE_NUM; k++) begin : g_lane
    lvds_deskew_fifo #(
      .C_WIDTH (W),
      .C_DEPTH (C_FIFO_DEPTH),
      .C_OCC_W (OCC_W)
    ) u_fifo (
      .clk_i     (CLKDIV_I),
      .rst_n_i   (CLKDIV_RST_N_I),
      .flush_i   (flush),
      .wr_i      (wr),
      .pop_i     (pop[k]),
      .wr_data_i (LANE_DATA_I[k*W +: W]),
      .head_o    (head[k]),
      .occ_o     (occ[k]),
      .empty_o   (empty[k])
    );
    assign heads[k*W +: W] = head[k];
  end

  always_comb begin
    ba_ok    = &BYTE_ALIGN_I;
    hold     = '0;
    any_full = 1'b0;
    for (int k = 0; k < C_LANE_NUM; k++) begin
      hold[k] = !empty[k] && (head[k] == C_SYNC_WORD);
      if (occ[k] == OCC_W'(C_FIFO_DEPTH - 1)) any_full = 1'b1;
    end
    all_hold = &hold;

    state_d  = state_q;
    tmo_d    = '0;
    pop_all  = 1'b0;
    pop_lane = '0;
    wr       = 1'b0;

    if ((state_q == ST_SEARCH || state_q == ST_LOCKED) && !ba_ok) begin
      state_d = ST_IDLE;
    end else if (DESKEW_REQ_I) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (ba_ok) state_d = ST_SEARCH;
        ST_SEARCH: begin
          wr = 1'b1;
          // Lock wins over a full lane: a lane at DEPTH-1 that locks this
          // cycle is the largest correctable skew.
          if (all_hold) begin
            pop_all = 1'b1;
            state_d = ST_LOCKED;
          end else begin
            pop_lane = ~hold & ~empty;
            tmo_d    = (tmo_q == TMO_W'(C_TIMEOUT)) ? tmo_q : tmo_q + TMO_W'(1);
            if (any_full || tmo_q == TMO_W'(C_TIMEOUT - 1)) state_d = ST_ERROR;
          end
        end
        ST_LOCKED: begin
          wr      = 1'b1;
          pop_all = 1'b1;
        end
        ST_ERROR: ;
        default: state_d = ST_IDLE;
      endcase
    end

    flush = (state_d == ST_IDLE) || (state_d == ST_ERROR);
    pop   = pop_all ? '1 : pop_lane;
  end

  always_ff @(posedge CLKDIV_I or negedge CLKDIV_RST_N_I) begin
    if (!CLKDIV_RST_N_I) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      vld_q   <= pop_all;
      if (pop_all) data_q <= heads;
    end
  end

  assign DATA_O        = data_q;
  assign DATA_VLD_O    = vld_q;
  assign DESKEW_DONE_O = (state_q == ST_LOCKED);
  assign DESKEW_ERR_O  = (state_q == ST_ERROR);

`ifdef LVDS_DESKEW_SKEW_MON_EN
  logic [C_LANE_NUM*AW-1:0] skew_q;

  always_ff @(posedge CLKDIV_I or negedge CLKDIV_RST_N_I) begin
    if (!CLKDIV_RST_N_I) begin
      skew_q <= '0;
    end else if (state_q == ST_SEARCH && state_d == ST_LOCKED) begin
      for (int k = 0; k < C_LANE_NUM; k++) skew_q[k*AW +: AW] <= occ[k][AW-1:0];
    end
  end

  assign LANE_SKEW_O = skew_q;
`endif

endmodule

// File: tb/tb_lvds_rx_lane_deskew.sv
// Randomized bench for lvds_rx_lane_deskew against a queue-based lane model,
// plus directed skew, timeout, align-drop and async-reset scenarios.
module tb_lvds_rx_lane_deskew;

  localparam int          L       = 2;
  localparam int          W       = 4;
  localparam int          DEPTH   = 8;
  localparam int          TIMEOUT = 256;
  localparam logic [3:0]  SYNC    = 4'b1100;
  localparam int          HIST    = 4096;

  localparam int S_IDLE = 0, S_SEARCH = 1, S_LOCKED = 2, S_ERROR = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   lane_data;
  logic [1:0]   byte_align;
  logic         req;
  logic [7:0]   data_o;
  logic         vld_o, done_o, err_o;
`ifdef LVDS_DESKEW_SKEW_MON_EN
  logic [5:0]   skew_o;
`endif

  always #5 clk = ~clk;

  lvds_rx_lane_deskew dut (
    .CLKDIV_I       (clk),
    .CLKDIV_RST_N_I (rst_n),
    .LANE_DATA_I    (lane_data),
    .BYTE_ALIGN_I   (byte_align),
    .DESKEW_REQ_I   (req),
    .DATA_O         (data_o),
    .DATA_VLD_O     (vld_o),
    .DESKEW_DONE_O  (done_o),
    .DESKEW_ERR_O   (err_o)
`ifdef LVDS_DESKEW_SKEW_MON_EN
    ,.LANE_SKEW_O   (skew_o)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stimulus source: a base stream with a sync word every 16 cycles, each lane
  // seeing it delayed by its own skew.
  logic [3:0] base_h [HIST];
  int         n = 16;
  int         dly [2];
  bit         nosync = 0;

  // Reference model state
  int         m_state;
  int         m_tmo;
  logic [3:0] mq0 [$];
  logic [3:0] mq1 [$];
  logic [7:0] m_data;
  bit         m_vld;
  int         m_skew [2];

  function automatic logic [3:0] lane_word(input int k);
    logic [3:0] v;
    v = base_h[(n - dly[k]) % HIST];
    if (nosync && v == SYNC) v = 4'h3;
    return v;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_tmo = 0; mq0.delete(); mq1.delete();
    m_data = '0; m_vld = 0; m_skew[0] = 0; m_skew[1] = 0;
  endtask

  task automatic model_flush();
    mq0.delete(); mq1.delete(); m_tmo = 0;
  endtask

  task automatic model_step(input logic [7:0] din, input logic [1:0] ba, input logic rq);
    int sz0, sz1;
    logic [3:0] h0, h1;
    bit hold0, hold1, err;
    sz0 = mq0.size(); sz1 = mq1.size();
    h0 = (sz0 > 0) ? mq0[0] : 4'h0;
    h1 = (sz1 > 0) ? mq1[0] : 4'h0;
    hold0 = (sz0 > 0) && (h0 == SYNC);
    hold1 = (sz1 > 0) && (h1 == SYNC);
    m_vld = 0;
    if ((m_state == S_SEARCH || m_state == S_LOCKED) && ba != 2'b11) begin
      m_state = S_IDLE; model_flush();
    end else if (rq) begin
      m_state = S_IDLE; model_flush();
    end else begin
      case (m_state)
        S_IDLE: begin
          model_flush();
          if (ba == 2'b11) m_state = S_SEARCH;
        end
        S_SEARCH: begin
          if (hold0 && hold1) begin
            m_skew[0] = sz0; m_skew[1] = sz1;
            m_data = {h1, h0}; m_vld = 1;
            void'(mq0.pop_front()); void'(mq1.pop_front());
            mq0.push_back(din[3:0]); mq1.push_back(din[7:4]);
            m_state = S_LOCKED; m_tmo = 0;
          end else begin
            err = (sz0 == DEPTH - 1) || (sz1 == DEPTH - 1) || (m_tmo + 1 >= TIMEOUT);
            if (sz0 > 0 && !hold0) void'(mq0.pop_front());
            if (sz1 > 0 && !hold1) void'(mq1.pop_front());
            mq0.push_back(din[3:0]); mq1.push_back(din[7:4]);
            if (err) begin
              m_state = S_ERROR; model_flush();
            end else begin
              m_tmo = m_tmo + 1;
            end
          end
        end
        S_LOCKED: begin
          m_data = {h1, h0}; m_vld = 1;
          void'(mq0.pop_front()); void'(mq1.pop_front());
          mq0.push_back(din[3:0]); mq1.push_back(din[7:4]);
        end
        default: model_flush();
      endcase
    end
  endtask

  task automatic compare_all();
    chk("vld",  {31'd0, vld_o},  {31'd0, m_vld});
    chk("done", {31'd0, done_o}, {31'd0, m_state == S_LOCKED});
    chk("err",  {31'd0, err_o},  {31'd0, m_state == S_ERROR});
    chk("data", {24'd0, data_o}, {24'd0, m_data});
`ifdef LVDS_DESKEW_SKEW_MON_EN
    chk("skew0", {29'd0, skew_o[2:0]}, m_skew[0]);
    chk("skew1", {29'd0, skew_o[5:3]}, m_skew[1]);
`endif
  endtask

  task automatic tick(input logic [1:0] ba, input logic rq);
    logic [7:0] din;
    din = {lane_word(1), lane_word(0)};
    lane_data = din; byte_align = ba; req = rq;
    @(posedge clk);
    model_step(din, ba, rq);
    n++;
    #1;
    compare_all();
  endtask

  task automatic wait_phase();
    for (int i = 0; i < 32 && (n % 16) != 12; i++) tick(2'b00, 1'b0);
  endtask

  task automatic wait_lock(input string tag, output int t);
    t = 0;
    while (!done_o && t < 64) begin
      tick(2'b11, 1'b0);
      t++;
    end
    chk(tag, {31'd0, done_o}, 32'd1);
  endtask

  initial begin
    int t;
    for (int i = 0; i < HIST; i++) begin
      logic [3:0] v;
      v = 4'($urandom_range(0, 15));
      if (v == SYNC) v = 4'h5;
      base_h[i] = (i % 16 == 0) ? SYNC : v;
    end
    dly[0] = 0; dly[1] = 0;
    rst_n = 1'b0; lane_data = '0; byte_align = '0; req = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Zero skew
    wait_phase();
    tick(2'b11, 1'b0);
    wait_lock("lock_zero", t);
    chk("lock_zero_le17", {31'd0, t <= 17}, 32'd1);
    repeat (20) tick(2'b11, 1'b0);
`ifdef LVDS_DESKEW_SKEW_MON_EN
    chk("skew_diff_zero", {29'd0, skew_o[2:0]} - {29'd0, skew_o[5:3]}, 32'd0);
`endif

    // Lane 1 delayed 3 cycles
    tick(2'b00, 1'b0);
    dly[1] = 3;
    wait_phase();
    tick(2'b11, 1'b0);
    wait_lock("lock_skew3", t);
    repeat (20) tick(2'b11, 1'b0);
`ifdef LVDS_DESKEW_SKEW_MON_EN
    chk("skew_diff_3", {29'd0, skew_o[2:0]} - {29'd0, skew_o[5:3]}, 32'd3);
`endif

    // Lane 1 delayed 7 cycles: uncorrectable
    tick(2'b00, 1'b0);
    dly[1] = 7;
    wait_phase();
    tick(2'b11, 1'b0);
    t = 0;
    while (!err_o && t < 40) begin tick(2'b11, 1'b0); t++; end
    chk("err_skew7", {31'd0, err_o}, 32'd1);
    chk("vld_in_err", {31'd0, vld_o}, 32'd0);
    tick(2'b11, 1'b1);
    chk("err_clear_req", {31'd0, err_o}, 32'd0);
    tick(2'b00, 1'b0);

    // No sync word at all: timeout
    nosync = 1; dly[1] = 0;
    wait_phase();
    tick(2'b11, 1'b0);
    t = 0;
    while (!err_o && t < 300) begin tick(2'b11, 1'b0); t++; end
    chk("timeout_cycles", t, TIMEOUT);
    nosync = 0;
    tick(2'b00, 1'b1);

    // Byte-align drop while locked
    dly[1] = 2;
    wait_phase();
    tick(2'b11, 1'b0);
    wait_lock("lock_skew2", t);
    for (int i = 0; i < 32 && (n % 16) != 12; i++) tick(2'b11, 1'b0);
    tick(2'b10, 1'b0);
    chk("drop_vld", {31'd0, vld_o}, 32'd0);
    chk("drop_done", {31'd0, done_o}, 32'd0);
    tick(2'b11, 1'b0);
    wait_lock("relock", t);
    repeat (5) tick(2'b11, 1'b0);

    // Asynchronous reset while locked
    rst_n = 1'b0;
    #1;
    chk("arst_vld",  {31'd0, vld_o},  32'd0);
    chk("arst_done", {31'd0, done_o}, 32'd0);
    chk("arst_data", {24'd0, data_o}, 32'd0);
    chk("arst_err",  {31'd0, err_o},  32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2'b00, 1'b0);
    chk("post_rst_done", {31'd0, done_o}, 32'd0);

    // Randomized soak
    for (int e = 0; e < 6; e++) begin
      dly[0] = $urandom_range(0, 7);
      dly[1] = $urandom_range(0, 7);
      tick(2'b00, 1'b1);
      for (int i = 0; i < 120; i++) begin
        logic [1:0] ba;
        ba = ($urandom_range(0, 63) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
        tick(ba, $urandom_range(0, 99) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
